// File: rtl/sub_flag_stage.sv
// Result stage behind the ripple subtractor: derives status flags, queues result+flags in a
// small circular FIFO with valid/ready on both sides, and counts signed-overflow pushes.
module sub_flag_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       sub_a,
   input  logic [WIDTH-1:0]       sub_b,
   input  logic [WIDTH-1:0]       sub_diff,
   input  logic                   sub_borrow,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_diff,
   output logic                   out_zero,
   output logic                   out_neg,
   output logic                   out_borrow,
   output logic                   out_ovf,
   output logic [$clog2(DEPTH):0] fill,
   output logic [CNT_W-1:0]       ovf_cnt,
   input  logic                   ovf_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;
   localparam logic [FW-1:0] FULL = FW'(DEPTH);

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [FW-1:0]    fill_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] mem_diff [DEPTH];
   logic [3:0]       mem_flg  [DEPTH];

   logic       push, pop;
   logic       in_ovf;
   logic [3:0] in_flags;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Overflow only possible when operand signs differ; then the result must keep a's sign.
   assign in_ovf   = (sub_a[WIDTH-1] != sub_b[WIDTH-1]) && (sub_diff[WIDTH-1] != sub_a[WIDTH-1]);
   assign in_flags = {(sub_diff == '0), sub_diff[WIDTH-1], sub_borrow, in_ovf};

   assign in_ready  = (fill_r != FULL);
   assign out_valid = (fill_r != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_r <= '0;
         cnt_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_diff[i] <= '0;
            mem_flg[i]  <= '0;
         end
      end else begin
         if (push) begin
            mem_diff[wr_ptr] <= sub_diff;
            mem_flg[wr_ptr]  <= in_flags;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fill_r <= fill_r + FW'(1);
            2'b01:   fill_r <= fill_r - FW'(1);
            default: fill_r <= fill_r;
         endcase
         // Clear wins over a same-cycle overflowing push.
         if (ovf_clr)
            cnt_r <= '0;
         else if (push && in_ovf)
            cnt_r <= sat_inc(cnt_r);
      end
   end

   assign out_diff   = mem_diff[rd_ptr];
   assign out_zero   = mem_flg[rd_ptr][3];
   assign out_neg    = mem_flg[rd_ptr][2];
   assign out_borrow = mem_flg[rd_ptr][1];
   assign out_ovf    = mem_flg[rd_ptr][0];
   assign fill       = fill_r;
   assign ovf_cnt    = cnt_r;

endmodule
